// File: rtl/doorlock_pkg.sv
// Shared types and constants for the door-lock controller.
// Build option: DOORLOCK_ALARM_EN enables the lockout/mismatch alarm output.
package doorlock_pkg;

  // Controller phases
  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
  } state_e;

  // Status display codes
  localparam logic [1:0] SEG_ENTRY   = 2'b00;
  localparam logic [1:0] SEG_OPEN    = 2'b01;
  localparam logic [1:0] SEG_LOCKED  = 2'b10;
  localparam logic [1:0] SEG_LOCKOUT = 2'b11;

  // Display code shown while the controller sits in a given state.
  function automatic logic [1:0] seg_of(state_e st);
    case (st)
      ENTRY:   seg_of = SEG_ENTRY;
      OPEN:    seg_of = SEG_OPEN;
      LOCKOUT: seg_of = SEG_LOCKOUT;
      default: seg_of = SEG_LOCKED;
    endcase
  endfunction

  // Largest of three cycle counts; sizes the shared phase timer.
  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/doorlock_if.sv
// Keypad / door / display signal bundle for the door-lock controller.
// Build option: DOORLOCK_ALARM_EN (alarm is always present as a signal).
interface doorlock_if #(
  parameter int unsigned FAIL_W = 2
);

  logic              key_valid;
  logic [3:0]        key_code;
  logic              key_clear;
  logic              door_close;
  logic              door_open;
  logic [1:0]        seg_out;
  logic [FAIL_W-1:0] fail_cnt;
  logic              alarm;

  // Keypad/sensor side: drives keys and door sensor, observes status
  modport master (
    output key_valid,
    output key_code,
    output key_clear,
    output door_close,
    input  door_open,
    input  seg_out,
    input  fail_cnt,
    input  alarm
  );

  // Controller side
  modport slave (
    input  key_valid,
    input  key_code,
    input  key_clear,
    input  door_close,
    output door_open,
    output seg_out,
    output fail_cnt,
    output alarm
  );

endinterface

// File: rtl/doorlock_timer.sv
// Single loadable down-counter shared by the entry-timeout, open and lockout
// phases. expired is high while the count sits at zero.
// Build option: DOORLOCK_ALARM_EN has no effect here.
module doorlock_timer #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// Door-lock sequencing controller: collects keypad digits, checks the code,
// counts consecutive failures, enforces lockout and times the door opening.
// Build option: define DOORLOCK_ALARM_EN to drive the alarm output; otherwise
// alarm is tied low and no alarm logic exists.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int unsigned            PW_DIGITS     = 4,
  parameter logic [4*PW_DIGITS-1:0] PASSWORD      = 16'h1D3A,
  parameter int unsigned            OPEN_CYCLES   = 1000,
  parameter int unsigned            MAX_FAIL      = 3,
  parameter int unsigned            LOCK_CYCLES   = 5000,
  parameter int unsigned            ENTRY_TIMEOUT = 2000
) (
  input logic       clk,
  input logic       rst_n,
  doorlock_if.slave bus
);

  localparam int unsigned PW_W    = 4 * PW_DIGITS;
  localparam int unsigned CNT_W   = $clog2(PW_DIGITS + 1);
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned MAX_CYC = max3(OPEN_CYCLES, LOCK_CYCLES, ENTRY_TIMEOUT);
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Timer loads are N-1 so the phase lasts exactly N cycles, leaving on the
  // cycle the counter reads zero.
  localparam logic [TMR_W-1:0] TMR_ENTRY = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_OPEN  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LOCK  = TMR_W'(LOCK_CYCLES - 1);

  state_e            state_q;
  logic [PW_W-1:0]   digits_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [FAIL_W-1:0] fail_q;
  logic              door_open_q;
  logic [1:0]        seg_q;
  // Set after the first OPEN cycle; door_close only relocks once armed
  logic              open_armed_q;

  logic              accept;
  logic [PW_W-1:0]   digits_shift;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_digit;
  logic              pw_match;
  logic [FAIL_W-1:0] fail_inc;
  logic              lock_hit;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              expired;

  // Decode of the current cycle: digit acceptance, compare, timer loads
  always_comb begin
    accept       = ((state_q == IDLE) || (state_q == ENTRY)) && bus.key_valid &&
                   !bus.key_clear;
    digits_shift = (digits_q << 4) | PW_W'(bus.key_code);
    cnt_inc      = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
    last_digit   = (cnt_inc == CNT_W'(PW_DIGITS));
    pw_match     = (digits_q == PASSWORD);
    fail_inc     = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
    lock_hit     = (fail_inc == FAIL_W'(MAX_FAIL));
    tmr_load     = 1'b0;
    tmr_val      = '0;
    if (accept) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_ENTRY;
    end else if (state_q == CHECK) begin
      if (pw_match) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_OPEN;
      end else if (lock_hit) begin
        tmr_load = 1'b1;
        tmr_val  = TMR_LOCK;
      end
    end
  end

  doorlock_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  // Main FSM; outputs are registered alongside the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      digits_q     <= '0;
      cnt_q        <= '0;
      fail_q       <= '0;
      door_open_q  <= 1'b0;
      seg_q        <= SEG_LOCKED;
      open_armed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if (bus.key_clear) begin
            // Clear beats a simultaneous digit; no failure is counted
            state_q  <= IDLE;
            seg_q    <= seg_of(IDLE);
            digits_q <= '0;
            cnt_q    <= '0;
          end else if (accept) begin
            digits_q <= digits_shift;
            cnt_q    <= cnt_inc;
            if (last_digit) begin
              state_q <= CHECK;
              seg_q   <= seg_of(CHECK);
            end else begin
              state_q <= ENTRY;
              seg_q   <= seg_of(ENTRY);
            end
          end else if ((state_q == ENTRY) && expired) begin
            // Abandoned entry; failure count is left alone
            state_q  <= IDLE;
            seg_q    <= seg_of(IDLE);
            digits_q <= '0;
            cnt_q    <= '0;
          end
        end
        CHECK: begin
          digits_q <= '0;
          cnt_q    <= '0;
          if (pw_match) begin
            state_q      <= OPEN;
            seg_q        <= seg_of(OPEN);
            door_open_q  <= 1'b1;
            fail_q       <= '0;
            open_armed_q <= 1'b0;
          end else begin
            fail_q <= fail_inc;
            if (lock_hit) begin
              state_q <= LOCKOUT;
              seg_q   <= seg_of(LOCKOUT);
            end else begin
              state_q <= IDLE;
              seg_q   <= seg_of(IDLE);
            end
          end
        end
        OPEN: begin
          open_armed_q <= 1'b1;
          if (expired || (bus.door_close && open_armed_q)) begin
            state_q     <= IDLE;
            seg_q       <= seg_of(IDLE);
            door_open_q <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (expired) begin
            state_q <= IDLE;
            seg_q   <= seg_of(IDLE);
            fail_q  <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          seg_q       <= SEG_LOCKED;
          door_open_q <= 1'b0;
          digits_q    <= '0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign bus.door_open = door_open_q;
  assign bus.seg_out   = seg_q;
  assign bus.fail_cnt  = fail_q;

`ifdef DOORLOCK_ALARM_EN
  logic alarm_q;

  // High on the cycle after a mismatch and for the whole of LOCKOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= ((state_q == CHECK) && !pw_match) || ((state_q == LOCKOUT) && !expired);
    end
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Self-checking bench for doorlock_ctrl (default parameters).
// Honours DOORLOCK_ALARM_EN when deciding the expected alarm level.
module tb_doorlock_ctrl;
  import doorlock_pkg::*;

`ifdef DOORLOCK_ALARM_EN
  localparam bit AlarmEn = 1'b1;
`else
  localparam bit AlarmEn = 1'b0;
`endif

  typedef struct {
    bit         kv;
    logic [3:0] code;
    bit         clr;
    bit         dc;
    bit         exp_open;
    logic [1:0] exp_seg;
    int         exp_fail;
    bit         exp_alarm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[23];

  doorlock_if #(.FAIL_W(2)) bus ();

  doorlock_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit kv, logic [3:0] code, bit clr, bit eo, logic [1:0] es,
                              int ef, bit ea);
    vec_t v;
    v.kv = kv; v.code = code; v.clr = clr; v.dc = 1'b0;
    v.exp_open = eo; v.exp_seg = es; v.exp_fail = ef; v.exp_alarm = ea;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_code  = d;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
  endtask

  task automatic count_seg(input logic [1:0] s, input int bound, output int n);
    n = 0;
    while ((bus.seg_out == s) && (n < bound)) begin
      step();
      n++;
    end
  endtask

  task automatic count_open(input int bound, output int n);
    n = 0;
    while ((bus.door_open == 1'b1) && (n < bound)) begin
      step();
      n++;
    end
  endtask

  task automatic check_outs(input string name, input bit eo, input logic [1:0] es,
                            input int ef);
    check({name, ".door_open"}, int'(bus.door_open), int'(eo));
    check({name, ".seg_out"}, int'(bus.seg_out), int'(es));
    check({name, ".fail_cnt"}, int'(bus.fail_cnt), ef);
  endtask

  initial begin
    int n;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    bus.key_clear  = 1'b0;
    bus.door_close = 1'b0;
    rst_n          = 1'b0;

    // Entry / clear / failure sequence leading into LOCKOUT
    vecs[0]  = mk(1, 4'h1, 0, 0, SEG_ENTRY,   0, 0);
    vecs[1]  = mk(1, 4'hD, 0, 0, SEG_ENTRY,   0, 0);
    vecs[2]  = mk(1, 4'h3, 0, 0, SEG_ENTRY,   0, 0);
    vecs[3]  = mk(1, 4'hB, 0, 0, SEG_LOCKED,  0, 0);
    vecs[4]  = mk(0, 4'h0, 0, 0, SEG_LOCKED,  1, 1);
    vecs[5]  = mk(1, 4'h1, 0, 0, SEG_ENTRY,   1, 0);
    vecs[6]  = mk(1, 4'hD, 0, 0, SEG_ENTRY,   1, 0);
    vecs[7]  = mk(1, 4'h3, 0, 0, SEG_ENTRY,   1, 0);
    vecs[8]  = mk(1, 4'hA, 1, 0, SEG_LOCKED,  1, 0);
    vecs[9]  = mk(0, 4'h0, 0, 0, SEG_LOCKED,  1, 0);
    vecs[10] = mk(0, 4'h0, 1, 0, SEG_LOCKED,  1, 0);
    vecs[11] = mk(1, 4'h1, 0, 0, SEG_ENTRY,   1, 0);
    vecs[12] = mk(1, 4'hD, 0, 0, SEG_ENTRY,   1, 0);
    vecs[13] = mk(1, 4'h3, 0, 0, SEG_ENTRY,   1, 0);
    vecs[14] = mk(1, 4'hB, 0, 0, SEG_LOCKED,  1, 0);
    vecs[15] = mk(0, 4'h0, 0, 0, SEG_LOCKED,  2, 1);
    vecs[16] = mk(1, 4'h1, 0, 0, SEG_ENTRY,   2, 0);
    vecs[17] = mk(1, 4'hD, 0, 0, SEG_ENTRY,   2, 0);
    vecs[18] = mk(1, 4'h3, 0, 0, SEG_ENTRY,   2, 0);
    vecs[19] = mk(1, 4'hB, 0, 0, SEG_LOCKED,  2, 0);
    vecs[20] = mk(0, 4'h0, 0, 0, SEG_LOCKOUT, 3, 1);
    vecs[21] = mk(1, 4'h1, 0, 0, SEG_LOCKOUT, 3, 1);
    vecs[22] = mk(0, 4'h0, 1, 0, SEG_LOCKOUT, 3, 1);

    // Reset values
    repeat (3) step();
    check_outs("reset", 1'b0, SEG_LOCKED, 0);
    check("reset.alarm", int'(bus.alarm), 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      bus.key_valid  = vecs[i].kv;
      bus.key_code   = vecs[i].code;
      bus.key_clear  = vecs[i].clr;
      bus.door_close = vecs[i].dc;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_open, vecs[i].exp_seg,
                 vecs[i].exp_fail);
      check($sformatf("vec%0d.alarm", i), int'(bus.alarm), int'(AlarmEn & vecs[i].exp_alarm));
    end
    bus.key_valid = 1'b0;
    bus.key_clear = 1'b0;

    // LOCKOUT lasts 5000 cycles; two were spent in vecs 21-22
    count_seg(SEG_LOCKOUT, 6000, n);
    check("lockout_len", n, 4998);
    check_outs("after_lockout", 1'b0, SEG_LOCKED, 0);
    check("after_lockout.alarm", int'(bus.alarm), 0);

    // Entry timeout keeps the failure count
    enter_code(16'h1D3B);
    step();
    check("timeout_pre.fail", int'(bus.fail_cnt), 1);
    press(4'h1);
    press(4'hD);
    count_seg(SEG_ENTRY, 2100, n);
    check("timeout_len", n, 2000);
    check_outs("after_timeout", 1'b0, SEG_LOCKED, 1);

    // Digit arriving in the expiry cycle is accepted
    press(4'h1);
    repeat (1999) step();
    check("pre_expiry.seg", int'(bus.seg_out), int'(SEG_ENTRY));
    press(4'hD);
    check("expiry_key.seg", int'(bus.seg_out), int'(SEG_ENTRY));
    press(4'h3);
    press(4'hA);
    check_outs("late_code.check", 1'b0, SEG_LOCKED, 1);
    step();
    check_outs("late_code.open", 1'b1, SEG_OPEN, 0);

    // Keys ignored in OPEN, door_close relocks early
    press(4'h1);
    press(4'hD);
    bus.key_clear = 1'b1;
    step();
    bus.key_clear = 1'b0;
    repeat (6) step();
    check_outs("open_keys", 1'b1, SEG_OPEN, 0);
    bus.door_close = 1'b1;
    step();
    bus.door_close = 1'b0;
    check_outs("door_close", 1'b0, SEG_LOCKED, 0);
    step();
    check("door_close.idle", int'(bus.seg_out), int'(SEG_LOCKED));

    // door_close in the first OPEN cycle is not honoured
    enter_code(16'h1D3A);
    step();
    bus.door_close = 1'b1;
    step();
    check("dc_first.open", int'(bus.door_open), 1);
    step();
    check("dc_second.open", int'(bus.door_open), 0);
    bus.door_close = 1'b0;

    // Full OPEN duration, latency from the last strobe
    enter_code(16'h1D3A);
    check("full.check_open", int'(bus.door_open), 0);
    step();
    check("full.open_seg", int'(bus.seg_out), int'(SEG_OPEN));
    count_open(1100, n);
    check("open_len", n, 1000);
    check("open_done.seg", int'(bus.seg_out), int'(SEG_LOCKED));

    // Asynchronous reset in the middle of OPEN
    enter_code(16'h1D3A);
    repeat (6) step();
    check("mid_open.door", int'(bus.door_open), 1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst_open", 1'b0, SEG_LOCKED, 0);
    #2 rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of LOCKOUT
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1D3B);
      step();
    end
    repeat (5) step();
    check_outs("mid_lock", 1'b0, SEG_LOCKOUT, 3);
    #2 rst_n = 1'b0;
    #1;
    check_outs("rst_lock", 1'b0, SEG_LOCKED, 0);
    check("rst_lock.alarm", int'(bus.alarm), 0);
    #2 rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
